// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and the memory macro.
// The arbiter uses the slave view; the requester/memory environment uses the master view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (instruction fetch vs load/store) for a single-ported memory
// with a fixed read latency; one transaction in flight at a time.
module mem_port_arbiter #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int MEM_LAT = 2
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);
  localparam logic [2:0] LAT_LOAD = 3'(MEM_LAT - 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t            state_reg;
  logic              owner_d_reg;
  logic              we_reg;
  logic              last_d_reg;
  logic [2:0]        cnt_reg;
  logic              if_rvalid_reg;
  logic              d_rvalid_reg;
  logic [DATA_W-1:0] if_rdata_reg;
  logic [DATA_W-1:0] d_rdata_reg;

  logic can_grant;
  logic pick_d;
  logic if_gnt;
  logic d_gnt;

  // Grants are gated by reset as well so every output reads 0 while reset is held.
  always_comb begin
    can_grant = (state_reg == S_IDLE) && reset;
    pick_d    = bus.d_req && (!bus.if_req || !last_d_reg);
    d_gnt     = can_grant && pick_d;
    if_gnt    = can_grant && bus.if_req && !pick_d;
  end

  assign bus.if_gnt    = if_gnt;
  assign bus.d_gnt     = d_gnt;
  assign bus.mem_en    = if_gnt || d_gnt;
  assign bus.mem_we    = d_gnt && bus.d_we;
  assign bus.mem_addr  = d_gnt ? bus.d_addr : (if_gnt ? bus.if_addr : {ADDR_W{1'b0}});
  assign bus.mem_wdata = (if_gnt || d_gnt) ? bus.d_wdata : {DATA_W{1'b0}};
  assign bus.busy      = (state_reg == S_WAIT);
  assign bus.if_rvalid = if_rvalid_reg;
  assign bus.d_rvalid  = d_rvalid_reg;
  assign bus.if_rdata  = if_rdata_reg;
  assign bus.d_rdata   = d_rdata_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= S_IDLE;
      owner_d_reg   <= 1'b0;
      we_reg        <= 1'b0;
      last_d_reg    <= 1'b0;
      cnt_reg       <= 3'd0;
      if_rvalid_reg <= 1'b0;
      d_rvalid_reg  <= 1'b0;
      if_rdata_reg  <= {DATA_W{1'b0}};
      d_rdata_reg   <= {DATA_W{1'b0}};
    end else begin
      if_rvalid_reg <= 1'b0;
      d_rvalid_reg  <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (if_gnt || d_gnt) begin
            owner_d_reg <= d_gnt;
            we_reg      <= d_gnt && bus.d_we;
            last_d_reg  <= d_gnt;
            cnt_reg     <= LAT_LOAD;
            state_reg   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_reg == 3'd0) begin
            // Stores complete without touching d_rdata; it keeps the last load value.
            if (owner_d_reg) begin
              d_rvalid_reg <= 1'b1;
              if (!we_reg) begin
                d_rdata_reg <= bus.mem_rdata;
              end
            end else begin
              if_rvalid_reg <= 1'b1;
              if_rdata_reg  <= bus.mem_rdata;
            end
            state_reg <= S_IDLE;
          end else begin
            cnt_reg <= cnt_reg - 3'd1;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: directed scenarios plus a randomized run against a cycle-count
// reference model; one DUT with MEM_LAT=2 and one with MEM_LAT=1.
module tb_mem_port_arbiter;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam logic [63:0] K = 64'h0000_0000_03E0_0000;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int n_tests = 0;
  int n_fail  = 0;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b0 ();
  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b1 ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(2)) dut0 (
    .clk(clk), .reset(reset), .bus(b0)
  );
  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .bus(b1)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] fdat(logic [63:0] a);
    return a * K;
  endfunction

  // Memory behind dut0: unwritten words read as fdat(addr); latency 2 via a 2-stage pipe.
  logic [63:0]  mem0 [0:511];
  logic [511:0] wr0 = '0;
  logic [63:0]  pipe0 [0:1];
  logic [63:0]  pipe1;
  always @(posedge clk) begin
    if (b0.mem_en && !b0.mem_we)
      pipe0[0] <= wr0[b0.mem_addr[12:4]] ? mem0[b0.mem_addr[12:4]] : fdat(b0.mem_addr);
    else
      pipe0[0] <= {$urandom, $urandom};
    pipe0[1] <= pipe0[0];
    if (b0.mem_en && b0.mem_we) begin
      mem0[b0.mem_addr[12:4]] <= b0.mem_wdata;
      wr0[b0.mem_addr[12:4]]  <= 1'b1;
    end
    pipe1 <= b1.mem_en ? fdat(b1.mem_addr) : {$urandom, $urandom};
  end
  assign b0.mem_rdata = pipe0[1];
  assign b1.mem_rdata = pipe1;

  function automatic logic [6:0] flags0();
    return {b0.if_gnt, b0.d_gnt, b0.mem_en, b0.mem_we, b0.busy, b0.if_rvalid, b0.d_rvalid};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    b0.if_req = 0; b0.if_addr = '0; b0.d_req = 0; b0.d_we = 0; b0.d_addr = '0; b0.d_wdata = '0;
    b1.if_req = 0; b1.if_addr = '0; b1.d_req = 0; b1.d_we = 0; b1.d_addr = '0; b1.d_wdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    b0.if_req = 1; b0.d_req = 1; b0.d_we = 1;
    b0.if_addr = 64'h40; b0.d_addr = 64'h80; b0.d_wdata = 64'h1234;
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_tests++;
      if ({flags0(), b0.mem_addr, b0.mem_wdata, b0.if_rdata, b0.d_rdata} !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs: flags=%b addr=%h wdata=%h ifr=%h dr=%h required all 0",
                 flags0(), b0.mem_addr, b0.mem_wdata, b0.if_rdata, b0.d_rdata);
      end
    end
    do_reset();
  endtask

  task automatic test_single_fetch();
    logic [3:0] exp_f;
    do_reset();
    b0.if_req = 1; b0.if_addr = 64'h40;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      exp_f = {c == 1, c == 1, (c == 2 || c == 3), c == 4};
      n_tests++;
      if ({b0.if_gnt, b0.mem_en, b0.busy, b0.if_rvalid} !== exp_f) begin
        n_fail++;
        $display("FAIL single_fetch_c%0d: gnt/en/busy/rv=%b required %b", c,
                 {b0.if_gnt, b0.mem_en, b0.busy, b0.if_rvalid}, exp_f);
      end
      if (c == 1) begin
        n_tests++;
        if (b0.mem_addr !== 64'h40 || b0.mem_we !== 1'b0) begin
          n_fail++;
          $display("FAIL single_fetch_addr: addr=%h we=%b required 40/0", b0.mem_addr, b0.mem_we);
        end
      end
      if (c == 4) begin
        n_tests++;
        if (b0.if_rdata !== 64'hF800_0000) begin
          n_fail++;
          $display("FAIL single_fetch_rdata: got %h required f8000000", b0.if_rdata);
        end
      end
      tick();
      b0.if_req = 0;
    end
  endtask

  task automatic test_tie();
    logic [1:0] exp_g;
    do_reset();
    b0.if_req = 1; b0.d_req = 1; b0.if_addr = 64'h200; b0.d_addr = 64'h300;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      exp_g = {(c == 4 || c == 10), (c == 1 || c == 7)};
      n_tests++;
      if ({b0.if_gnt, b0.d_gnt} !== exp_g) begin
        n_fail++;
        $display("FAIL tie_c%0d: if_gnt/d_gnt=%b required %b", c, {b0.if_gnt, b0.d_gnt}, exp_g);
      end
      tick();
    end
    idle_inputs();
    repeat (3) tick();
  endtask

  task automatic test_store_load();
    do_reset();
    for (int c = 1; c <= 7; c++) begin
      if (c == 1) begin
        b0.d_req = 1; b0.d_we = 1; b0.d_addr = 64'h100; b0.d_wdata = 64'hDEAD_BEEF;
      end else if (c == 4) begin
        b0.d_req = 1; b0.d_we = 0; b0.d_addr = 64'h100; b0.d_wdata = '0;
      end
      @(negedge clk);
      if (c == 1) begin
        n_tests++;
        if ({b0.d_gnt, b0.mem_we} !== 2'b11 || b0.mem_wdata !== 64'hDEAD_BEEF || b0.mem_addr !== 64'h100) begin
          n_fail++;
          $display("FAIL store_strobe: gnt/we=%b wdata=%h addr=%h required 11/deadbeef/100",
                   {b0.d_gnt, b0.mem_we}, b0.mem_wdata, b0.mem_addr);
        end
      end
      if (c == 4) begin
        n_tests++;
        if ({b0.d_rvalid, b0.d_gnt, b0.mem_we} !== 3'b110 || b0.d_rdata !== 64'h0) begin
          n_fail++;
          $display("FAIL store_complete: rv/gnt/we=%b d_rdata=%h required 110/0",
                   {b0.d_rvalid, b0.d_gnt, b0.mem_we}, b0.d_rdata);
        end
      end
      if (c == 7) begin
        n_tests++;
        if (b0.d_rvalid !== 1'b1 || b0.d_rdata !== 64'hDEAD_BEEF || b0.if_rdata !== 64'h0) begin
          n_fail++;
          $display("FAIL load_after_store: rv=%b d_rdata=%h if_rdata=%h required 1/deadbeef/0",
                   b0.d_rvalid, b0.d_rdata, b0.if_rdata);
        end
      end
      tick();
      b0.d_req = 0;
    end
  endtask

  task automatic test_busy_req();
    do_reset();
    b0.d_req = 1; b0.d_we = 0; b0.d_addr = 64'h80;
    for (int c = 1; c <= 7; c++) begin
      if (c == 2) begin
        b0.if_req = 1; b0.if_addr = 64'h40;
      end
      @(negedge clk);
      if (c == 2 || c == 3) begin
        n_tests++;
        if ({b0.if_gnt, b0.busy} !== 2'b01) begin
          n_fail++;
          $display("FAIL busy_ignore_c%0d: if_gnt/busy=%b required 01", c, {b0.if_gnt, b0.busy});
        end
      end
      if (c == 4) begin
        n_tests++;
        if ({b0.if_gnt, b0.d_rvalid, b0.busy} !== 3'b110 || b0.d_rdata !== fdat(64'h80)) begin
          n_fail++;
          $display("FAIL busy_response: gnt/rv/busy=%b d_rdata=%h required 110/%h",
                   {b0.if_gnt, b0.d_rvalid, b0.busy}, b0.d_rdata, fdat(64'h80));
        end
      end
      if (c == 7) begin
        n_tests++;
        if (b0.if_rvalid !== 1'b1 || b0.if_rdata !== 64'hF800_0000) begin
          n_fail++;
          $display("FAIL busy_fetch_done: rv=%b if_rdata=%h required 1/f8000000", b0.if_rvalid, b0.if_rdata);
        end
      end
      tick();
      b0.d_req = 0;
      if (c == 4) b0.if_req = 0;
    end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    b0.if_req = 1; b0.if_addr = 64'h40;
    tick();
    b0.if_req = 0;
    repeat (2) tick();
    @(negedge clk);
    n_tests++;
    if (b0.if_rvalid !== 1'b1 || b0.if_rdata !== 64'hF800_0000) begin
      n_fail++;
      $display("FAIL rmw_setup: rv=%b if_rdata=%h required 1/f8000000", b0.if_rvalid, b0.if_rdata);
    end
    b0.if_req = 1; b0.if_addr = 64'h80;
    tick();
    reset = 1'b0;
    b0.if_req = 1; b0.d_req = 1; b0.d_addr = 64'h90;
    #1;
    for (int c = 0; c < 3; c++) begin
      n_tests++;
      if ({flags0(), b0.mem_addr, b0.mem_wdata, b0.if_rdata, b0.d_rdata} !== '0) begin
        n_fail++;
        $display("FAIL rmw_reset_c%0d: flags=%b addr=%h ifr=%h dr=%h required all 0",
                 c, flags0(), b0.mem_addr, b0.if_rdata, b0.d_rdata);
      end
      @(negedge clk);
    end
    tick();
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_tests++;
      if ({b0.if_rvalid, b0.d_gnt, b0.if_gnt, b0.d_rvalid} !== {1'b0, c == 0, 1'b0, c == 3}) begin
        n_fail++;
        $display("FAIL rmw_after_c%0d: if_rv/d_gnt/if_gnt/d_rv=%b required %b", c,
                 {b0.if_rvalid, b0.d_gnt, b0.if_gnt, b0.d_rvalid}, {1'b0, c == 0, 1'b0, c == 3});
      end
      tick();
      idle_inputs();
    end
  endtask

  task automatic test_lat1_back_to_back();
    logic [63:0] aq[$];
    logic [63:0] addr;
    logic [63:0] exp_d;
    logic [2:0]  exp_f;
    do_reset();
    addr = 64'(16 * $urandom_range(0, 255));
    for (int c = 1; c <= 12; c++) begin
      b1.if_req = 1; b1.if_addr = addr;
      @(negedge clk);
      exp_f = {c % 2 == 1, (c % 2 == 1) && c >= 3, c % 2 == 0};
      n_tests++;
      if ({b1.if_gnt, b1.if_rvalid, b1.busy} !== exp_f) begin
        n_fail++;
        $display("FAIL lat1_c%0d: gnt/rv/busy=%b required %b", c, {b1.if_gnt, b1.if_rvalid, b1.busy}, exp_f);
      end
      if (exp_f[1] && aq.size() > 0) begin
        exp_d = fdat(aq.pop_front());
        n_tests++;
        if (b1.if_rdata !== exp_d) begin
          n_fail++;
          $display("FAIL lat1_rdata_c%0d: got %h required %h", c, b1.if_rdata, exp_d);
        end
      end
      if (exp_f[2]) aq.push_back(addr);
      tick();
      if (exp_f[2]) addr = 64'(16 * $urandom_range(0, 255));
    end
    idle_inputs();
    repeat (2) tick();
  endtask

  // Reference model works in cycle numbers: port is free once c >= free_at.
  task automatic test_random();
    logic [63:0] ref_mem [0:7];
    bit ip, dp, dwe, last_d, gi, gd, rsp_d, rsp_rd;
    int ik, dk, free_at, rsp_due;
    logic [63:0] dwd, rsp_data, exp_ifr, exp_dr, exp_addr;
    logic [4:0] exp_f;
    for (int i = 0; i < 8; i++) ref_mem[i] = fdat(64'h1000 + 64'(16 * i));
    ip = 0; dp = 0; dwe = 0; ik = 0; dk = 0; dwd = '0;
    last_d = 0; free_at = 0; rsp_due = -1; rsp_d = 0; rsp_rd = 0; rsp_data = '0;
    exp_ifr = '0; exp_dr = '0;
    do_reset();
    for (int c = 1; c <= 300; c++) begin
      if (!ip && $urandom_range(0, 1) == 1) begin
        ip = 1; ik = $urandom_range(0, 7);
      end
      if (!dp && $urandom_range(0, 1) == 1) begin
        dp = 1; dk = $urandom_range(0, 7); dwe = 1'($urandom_range(0, 1)); dwd = {$urandom, $urandom};
      end
      b0.if_req = ip; b0.if_addr = ip ? 64'h1000 + 64'(16 * ik) : '0;
      b0.d_req = dp; b0.d_we = dp & dwe; b0.d_addr = dp ? 64'h1000 + 64'(16 * dk) : '0;
      b0.d_wdata = dp ? dwd : '0;
      gi = 0; gd = 0;
      if (c >= free_at) begin
        if (dp && (!ip || !last_d)) gd = 1;
        else if (ip) gi = 1;
      end
      exp_f = {gi, gd, c < free_at, rsp_due == c && !rsp_d, rsp_due == c && rsp_d};
      if (rsp_due == c && rsp_rd) begin
        if (rsp_d) exp_dr = rsp_data;
        else exp_ifr = rsp_data;
      end
      exp_addr = gd ? 64'h1000 + 64'(16 * dk) : (gi ? 64'h1000 + 64'(16 * ik) : 64'h0);
      @(negedge clk);
      n_tests++;
      if ({b0.if_gnt, b0.d_gnt, b0.busy, b0.if_rvalid, b0.d_rvalid} !== exp_f ||
          b0.mem_en !== (gi | gd) || b0.mem_we !== (gd & dwe) || b0.mem_addr !== exp_addr) begin
        n_fail++;
        $display("FAIL random_ctrl_c%0d: gi/gd/busy/irv/drv=%b en=%b we=%b addr=%h required %b/%b/%b/%h",
                 c, {b0.if_gnt, b0.d_gnt, b0.busy, b0.if_rvalid, b0.d_rvalid}, b0.mem_en, b0.mem_we,
                 b0.mem_addr, exp_f, gi | gd, gd & dwe, exp_addr);
      end
      n_tests++;
      if (b0.if_rdata !== exp_ifr || b0.d_rdata !== exp_dr) begin
        n_fail++;
        $display("FAIL random_rdata_c%0d: if_rdata=%h d_rdata=%h required %h/%h",
                 c, b0.if_rdata, b0.d_rdata, exp_ifr, exp_dr);
      end
      if (gi || gd) begin
        free_at = c + 3;
        rsp_due = c + 3;
        last_d  = gd;
        rsp_d   = gd;
        rsp_rd  = gi || !dwe;
        rsp_data = gd ? ref_mem[dk] : ref_mem[ik];
        if (gd && dwe) ref_mem[dk] = dwd;
        if (gd) dp = 0;
        else ip = 0;
      end
      tick();
    end
    idle_inputs();
    repeat (4) tick();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_fetch();
    test_tie();
    test_store_load();
    test_busy_req();
    test_reset_mid_wait();
    test_lat1_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
